// File: rtl/mm_tile_engine.sv
// mm_tile_engine: tiled matrix multiply OUT(TxM) = IN(TxN) x W(NxM).
// Weights are read column by column into LANES lane buffers. Every input
// row is then streamed against those lanes to produce one output word.
// The output SRAM is covered tile by tile, and unused rows and lanes are
// written as zero.
module mm_tile_engine #(
    parameter int MAXDIM = 8,
    parameter int DW     = 4,
    parameter int ODW    = 16,
    parameter int LANES  = 4,
    parameter int AW     = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [11:0]             mnt,
    input  logic                    acc,
    input  logic                    sgn,
    output logic                    en_w,
    output logic [AW-1:0]           addr_w,
    input  logic [MAXDIM*DW-1:0]    rdata_w,
    output logic                    en_i,
    output logic [AW-1:0]           addr_i,
    input  logic [MAXDIM*DW-1:0]    rdata_i,
    output logic                    en_o,
    output logic                    rw_o,
    output logic [AW-1:0]           addr_o,
    output logic [LANES*ODW-1:0]    wdata_o,
    input  logic [LANES*ODW-1:0]    rdata_o,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int IW = MAXDIM * DW;
    localparam int OW = LANES * ODW;

    typedef enum logic [2:0] {S_IDLE, S_LDW, S_RDI, S_WR, S_DONE} state_t;
    typedef logic [7:0] idx_t;

    localparam idx_t MAX_I   = idx_t'(MAXDIM);
    localparam idx_t LANES_I = idx_t'(LANES);
    localparam idx_t TILES_I = idx_t'(MAXDIM / LANES);

    state_t         state;
    idx_t           m, n, tl;
    idx_t           g, k, t;
    logic           acc_q, sgn_q;
    logic           row_data;
    logic [IW-1:0]  lane_buf [LANES];

    idx_t new_m, new_n, new_t;
    logic illegal;

    assign new_m   = idx_t'(mnt[11:8]);
    assign new_n   = idx_t'(mnt[7:4]);
    assign new_t   = idx_t'(mnt[3:0]);
    assign illegal = (new_m == 8'd0) || (new_m > MAX_I) ||
                     (new_n == 8'd0) || (new_n > MAX_I) ||
                     (new_t == 8'd0) || (new_t > MAX_I);

    // Sequencer: each edge finishes the current cycle and registers the next cycle's outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            m        <= '0;
            n        <= '0;
            tl       <= '0;
            g        <= '0;
            k        <= '0;
            t        <= '0;
            acc_q    <= 1'b0;
            sgn_q    <= 1'b0;
            row_data <= 1'b0;
            en_w     <= 1'b0;
            addr_w   <= '0;
            en_i     <= 1'b0;
            addr_i   <= '0;
            en_o     <= 1'b0;
            rw_o     <= 1'b0;
            addr_o   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m     <= new_m;
                        n     <= new_n;
                        tl    <= new_t;
                        acc_q <= acc;
                        sgn_q <= sgn;
                        if (illegal) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            err    <= 1'b0;
                            busy   <= 1'b1;
                            g      <= '0;
                            k      <= '0;
                            en_w   <= 1'b1;
                            addr_w <= '0;
                            state  <= S_LDW;
                        end
                    end
                end
                S_LDW: begin
                    if (k < LANES_I) begin
                        k      <= k + 8'd1;
                        en_w   <= (k + 8'd1 < LANES_I) && (g * LANES_I + k + 8'd1 < m);
                        addr_w <= AW'(g * LANES_I + k + 8'd1);
                    end else begin
                        // Row 0 always carries data because T >= 1 for a legal job.
                        en_w   <= 1'b0;
                        t      <= '0;
                        en_i   <= 1'b1;
                        addr_i <= '0;
                        en_o   <= acc_q;
                        rw_o   <= 1'b0;
                        addr_o <= AW'(g * MAX_I);
                        state  <= S_RDI;
                    end
                end
                S_RDI: begin
                    en_i     <= 1'b0;
                    en_o     <= 1'b1;
                    rw_o     <= 1'b1;
                    addr_o   <= AW'(g * MAX_I + t);
                    row_data <= 1'b1;
                    state    <= S_WR;
                end
                S_WR: begin
                    if (t + 8'd1 < MAX_I) begin
                        t <= t + 8'd1;
                        if (t + 8'd1 < tl) begin
                            en_i   <= 1'b1;
                            addr_i <= AW'(t + 8'd1);
                            en_o   <= acc_q;
                            rw_o   <= 1'b0;
                            addr_o <= AW'(g * MAX_I + t + 8'd1);
                            state  <= S_RDI;
                        end else begin
                            row_data <= 1'b0;
                            en_o     <= 1'b1;
                            rw_o     <= 1'b1;
                            addr_o   <= AW'(g * MAX_I + t + 8'd1);
                            state    <= S_WR;
                        end
                    end else begin
                        row_data <= 1'b0;
                        en_o     <= 1'b0;
                        rw_o     <= 1'b0;
                        if (g + 8'd1 < TILES_I) begin
                            g      <= g + 8'd1;
                            k      <= '0;
                            en_w   <= ((g + 8'd1) * LANES_I < m);
                            addr_w <= AW'((g + 8'd1) * LANES_I);
                            state  <= S_LDW;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Weight lane capture, one cycle after each column read; lanes beyond M hold zero.
    // NOTE: the lane buffer has no reset; every lane is rewritten in LDW before any row reads it.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (state == S_LDW && k == idx_t'(l + 1)) begin
                lane_buf[l] <= (g * LANES_I + idx_t'(l) < m) ? rdata_w : '0;
            end
        end
    end

    // Write data: per-lane dot product of the current input row, optionally added to the old word.
    always_comb begin : dot_calc
        logic [ODW-1:0]  lane_sum;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] prod;
        // NOTE: every variable gets a default first so no path can leave a latch behind.
        wdata_o  = '0;
        lane_sum = '0;
        a        = '0;
        b        = '0;
        prod     = '0;
        if (state == S_WR && row_data) begin
            for (int l = 0; l < LANES; l++) begin
                // NOTE: blocking assignments here because lane_sum chains within one evaluation.
                lane_sum = acc_q ? rdata_o[OW-1-l*ODW -: ODW] : '0;
                for (int e = 0; e < MAXDIM; e++) begin
                    a = rdata_i[IW-1-e*DW -: DW];
                    b = lane_buf[l][IW-1-e*DW -: DW];
                    if (sgn_q) begin
                        prod = $signed(a) * $signed(b);
                    end else begin
                        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
                    end
                    if (idx_t'(e) < n) begin
                        lane_sum = lane_sum + (sgn_q ? {{(ODW-2*DW){prod[2*DW-1]}}, prod}
                                                     : {{(ODW-2*DW){1'b0}}, prod});
                    end
                end
                if (g * LANES_I + idx_t'(l) >= m) begin
                    lane_sum = '0;
                end
                wdata_o[OW-1-l*ODW -: ODW] = lane_sum;
            end
        end
    end

endmodule

// File: doc/mm_tile_engine.md
# mm_tile_engine

Parametrised successor to the fixed 8x8 MAC array. It computes OUT(TxM) = IN(TxN) x W(NxM) from the input SRAM and the transposed-weight SRAM, and writes the result to the 64-bit output SRAM in column tiles, zero-filling every unused slot. Over the fixed array it adds configurable element and result widths, a configurable lane and tile count, signed mode, and accumulate mode (read-modify-write of the output). It also reports illegal dimensions and drives a BUSY/DONE handshake.

## Interface
- MAXDIM, 8, max M/N/T; legal range 1..15; must be divisible by LANES
- DW, 4, input/weight element width
- ODW, 16, result element width; ODW >= 2*DW + clog2(MAXDIM)
- LANES, 4, result elements per output word (one tile = LANES columns)
- AW, 4, SRAM address width; TILES*MAXDIM <= 2^AW
- Derived: IW = MAXDIM*DW, OW = LANES*ODW, TILES = MAXDIM/LANES
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- START  in  1  job request, level-sampled in IDLE
- MNT  in  12  M=[11:8], N=[7:4], T=[3:0]; latched at start
- ACC  in  1  accumulate mode, latched at start
- SGN  in  1  signed (two's-complement) mode, latched at start
- EN_W / ADDR_W / RDATA_W  out 1 / out AW / in IW  weight SRAM, read-only
- EN_I / ADDR_I / RDATA_I  out 1 / out AW / in IW  input SRAM, read-only
- EN_O / RW_O / ADDR_O  out 1 / out 1 / out AW  output SRAM enable, write when RW_O=1, address
- WDATA_O  out OW / RDATA_O in OW  output SRAM write and read data
- BUSY  out 1  job in progress
- DONE  out 1  job finished; held until START=0
- ERR  out 1  last job rejected; cleared at next start

## Operation
- SRAM read data is valid the cycle after EN=1.
- Packing: element k of a word occupies bits [W-1-k*DW -: DW], MSB-first. Lane l occupies [OW-1-l*ODW -: ODW].
- States: IDLE, LDW, RDI, WR, DONE.
- IDLE → START=1 latches MNT, ACC and SGN.
  - If any of M, N, T is 0 or greater than MAXDIM: set ERR, go to DONE with no memory access.
  - Otherwise go to LDW with tile g=0.
- LDW, LANES+1 cycles, cycle k=0..LANES-1:
  - If j=g*LANES+k < M: issue EN_W=1, ADDR_W=j.
  - Capture into lane buffer k one cycle later.
  - Lanes with j >= M load zero.
- Per tile, rows t=0..MAXDIM-1, in order:
  - t<T, cycle RDI: EN_I=1, ADDR_I=t. If ACC: EN_O=1, RW_O=0, ADDR_O=g*MAXDIM+t in the same cycle.
  - t<T, cycle WR: EN_O=1, RW_O=1, ADDR_O=g*MAXDIM+t, lane l written with dot(IN row t, W lane l).
  - t>=T: single WR cycle writing all zeros.
- Dot product:
  - Elements k >= N are masked to zero on both operands.
  - Products are 2*DW bits, sign-extended when SGN=1, zero-extended otherwise; sum in ODW bits.
  - ACC=1: lane result = RDATA_O lane + dot, modulo 2^ODW.
  - Lanes with j >= M are written 0 in every mode.
- After the last row of a tile: g+1 < TILES → LDW; otherwise → DONE.
- DONE: BUSY=0, DONE=1; START=0 → IDLE.
- START high while BUSY is ignored.
- RSTN low at any time, including mid-job: immediate return to IDLE. An aborted job leaves the output SRAM partially written.

## Timing
- Reset values: every output is 0, including EN_*, RW_O, all addresses, WDATA_O, BUSY, DONE and ERR.
- Start cycle: START is sampled at edge e0. BUSY=1 from e0. The first LDW access happens in the cycle after e0.
- Job length = TILES*(LANES+1 + 2*T + (MAXDIM-T)) cycles. DONE rises on the edge after the final write.
  - MNT=333 with defaults: 32 cycles.
  - MNT=888 with defaults: 2*(5+16) = 42 cycles.
- ERR path: DONE=1 and ERR=1 one cycle after e0. BUSY never asserts.
- Every output address 0..TILES*MAXDIM-1 is written exactly once per legal job.
- EN_W, EN_I and EN_O are registered outputs. At most one output-SRAM access per cycle.

## Test plan
- MNT=333, IN rows = 1,2,3 in columns 1..3, W = identity → addr0 = 0x0001000000000000 (lane0=1, other lanes 0), addr1 lane1=2, addr2 lane2=3; addrs 3..15 = 0; DONE 32 cycles after START.
- MNT=888, all elements 1, SGN=0 → all 16 addrs = 0x0008000800080008; DONE at 42 cycles.
- MNT=888, IN all 0xF, W all 0x1, SGN=1 → every lane 0xFFF8 (-8); with SGN=0 → every lane 0x0078.
- ACC=1 repeat of the all-ones 888 job, output preloaded by a prior run → every lane 0x0010.
- MNT=033 or MNT=933 → ERR=1 and DONE=1 one cycle after START; no EN_W/EN_I/EN_O pulse; START=0 → IDLE.
- RSTN pulsed low mid-job (MNT=888, cycle 20) → all outputs 0 immediately; rerun with START → correct results; START held high after DONE → no restart.
